apb_master: RTL and testbench
=============================

APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL have parameter DW, default 32, APB data width.
REQ-002 SHALL have parameter AW, default 16, APB address width.
REQ-003 SHALL have parameter TIMEOUT, default 16, maximum ACCESS wait cycles; 0 disables the timeout.
REQ-004 SHALL have port PCLK, input, 1, clock; all logic runs on its rising edge.
REQ-005 SHALL have port PRESETn, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have cmd_valid, input, 1, host request valid; cmd_ready, output, 1, block can accept a request.
REQ-007 SHALL have cmd_write, input, 1, 1=write 0=read; cmd_addr, input, AW, address; cmd_wdata, input, DW, write data.
REQ-008 SHALL have rsp_valid, output, 1, response valid; rsp_ready, input, 1, host accepts the response.
REQ-009 SHALL have rsp_rdata, output, DW, read data; rsp_err, output, 1, slave error or timeout.
REQ-010 SHALL have PSEL, PENABLE and PWRITE, output, 1 each; PADDR, output, AW; PWDATA, output, DW.
REQ-011 SHALL have PRDATA, input, DW; PREADY, input, 1; PSLVERR, input, 1.

Function
REQ-012 SHALL implement an FSM with states IDLE, SETUP, ACCESS and RESP.
REQ-013 SHALL assert cmd_ready only in IDLE; a request is accepted on an edge where cmd_valid and cmd_ready are both 1, and the FSM moves IDLE->SETUP.
REQ-014 SHALL register cmd_write, cmd_addr and cmd_wdata at acceptance and hold PWRITE, PADDR and PWDATA stable from SETUP through the last ACCESS cycle.
REQ-015 SHALL in SETUP drive PSEL=1 and PENABLE=0 for exactly one cycle, then move to ACCESS.
REQ-016 SHALL in ACCESS drive PSEL=1 and PENABLE=1, and remain in ACCESS while PREADY=0.
REQ-017 SHALL complete the transfer on the edge where the FSM is in ACCESS and PREADY=1.
  - On completion: capture rsp_err=PSLVERR.
  - For a read: capture rsp_rdata=PRDATA.
  - For a write: rsp_rdata=0.
  - Move to RESP.
REQ-018 SHALL count consecutive ACCESS cycles with PREADY=0 when TIMEOUT>0.
  - When the count reaches TIMEOUT, complete with rsp_err=1 and rsp_rdata=0, then move to RESP.
  - PREADY=1 on that same edge takes priority, and normal completion applies.
REQ-019 SHALL in RESP drive rsp_valid=1 and PSEL=PENABLE=0, with rsp_rdata and rsp_err held stable; it moves to IDLE on the edge where rsp_ready=1.
REQ-020 SHALL add no extra latency: an already-asserted rsp_ready gives accept->rsp_valid in 3 cycles with zero wait states, and the next command can be accepted 1 cycle after the response handshake.
REQ-021 SHALL ignore cmd_valid outside IDLE; PRDATA and PSLVERR SHALL be ignored outside the completing ACCESS edge.
REQ-022 SHALL drive PENABLE=0 whenever PSEL=0, and SHALL never deassert PSEL between SETUP and completion.

Reset
REQ-023 SHALL on PRESETn=0 immediately force the FSM to IDLE.
  - Forced to 0: PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err and the timeout counter.
  - cmd_ready=1 once PRESETn is high.
REQ-024 SHALL abort a transfer in progress on reset mid-operation without producing a response; after release, the first cmd_valid is accepted normally.

Structure
REQ-025 SHALL place the FSM state enumeration and the default DW, AW and TIMEOUT constants in a shared package apb_pkg.
REQ-026 SHALL implement the wait-state counter as a sub-module apb_timeout_cnt.
  - Inputs: clear, enable.
  - Output: expired.
  - Width: clog2(TIMEOUT+1).
REQ-027 SHALL register all APB outputs, with no combinational path from cmd_* to P* signals.

Verification
REQ-028 Write, zero wait: cmd_write=1, addr=0x0004, wdata=0xDEADBEEF, PREADY=1 -> one SETUP cycle then one ACCESS cycle with PADDR=0x0004, PWDATA=0xDEADBEEF; rsp_valid on cycle 3, rsp_err=0.
REQ-029 Read with waits: read addr=0x0004, PREADY low 3 cycles, PRDATA=0xDEADBEEF on the PREADY edge -> 4 ACCESS cycles, PADDR stable, rsp_rdata=0xDEADBEEF.
REQ-030 Slave error: read addr=0x000C, PSLVERR=1 with PREADY=1 -> rsp_err=1, rsp_rdata=PRDATA.
REQ-031 Timeout: TIMEOUT=4, PREADY held 0 -> exactly 4 ACCESS cycles, then rsp_err=1, rsp_rdata=0, PSEL=0.
REQ-032 Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid and data held, cmd_ready=0 throughout; a second cmd_valid is not accepted until 1 cycle after the handshake.
REQ-033 Reset mid-ACCESS: PRESETn pulsed low in the ACCESS state -> PSEL=PENABLE=0 asynchronously, no rsp_valid, cmd_ready=1 after release.

Source files
------------

// File: rtl/apb_pkg.sv
// ============================================================================
// Module  : apb_pkg
// Brief   : Shared FSM state encoding and default parameters for apb_master.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package apb_pkg;

    localparam int DEF_DW      = 32;
    localparam int DEF_AW      = 16;
    localparam int DEF_TIMEOUT = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

    // Counter width that can hold values 0..timeout (at least one bit).
    function automatic int cnt_width(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/apb_timeout_cnt.sv
// ============================================================================
// Module  : apb_timeout_cnt
// Brief   : Consecutive wait-state counter; flags the wait that hits TIMEOUT.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_timeout_cnt
    import apb_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic PCLK,
    input  logic PRESETn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = cnt_width(TIMEOUT);

    generate
        if (TIMEOUT > 0) begin : g_cnt
            localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT - 1);

            logic [CW-1:0] cnt_q;
            logic [CW-1:0] cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (clear) begin
                    cnt_d = '0;
                end else if (enable) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            always_ff @(posedge PCLK or negedge PRESETn) begin
                if (!PRESETn) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            // Asserted during the wait cycle whose edge would make the count reach TIMEOUT.
            assign expired = enable && !clear && (cnt_q == C_LAST);
        end else begin : g_none
            assign expired = 1'b0;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/apb_master.sv
// ============================================================================
// Module  : apb_master
// Brief   : Single-outstanding command/response to APB master bridge.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_master
    import apb_pkg::*;
#(
    parameter int DW      = DEF_DW,
    parameter int AW      = DEF_AW,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic          PCLK,
    input  logic          PRESETn,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic          PSEL,
    output logic          PENABLE,
    output logic          PWRITE,
    output logic [AW-1:0] PADDR,
    output logic [DW-1:0] PWDATA,
    input  logic [DW-1:0] PRDATA,
    input  logic          PREADY,
    input  logic          PSLVERR
);

    apb_state_e    state_q,     state_d;
    logic          cmd_ready_q, cmd_ready_d;
    logic          psel_q,      psel_d;
    logic          penable_q,   penable_d;
    logic          pwrite_q,    pwrite_d;
    logic [AW-1:0] paddr_q,     paddr_d;
    logic [DW-1:0] pwdata_q,    pwdata_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
    logic          rsp_err_q,   rsp_err_d;

    logic          tmo_clear;
    logic          tmo_enable;
    logic          tmo_expired;

    assign tmo_clear  = (state_q != ST_ACCESS);
    assign tmo_enable = (state_q == ST_ACCESS) && !PREADY;

    apb_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_cnt (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .clear   (tmo_clear),
        .enable  (tmo_enable),
        .expired (tmo_expired)
    );

    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_d   = ST_SETUP;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    pwrite_d  = cmd_write;
                    paddr_d   = cmd_addr;
                    pwdata_d  = cmd_wdata;
                end
            end
            ST_SETUP: begin
                state_d   = ST_ACCESS;
                penable_d = 1'b1;
            end
            ST_ACCESS: begin
                // PREADY wins over an expiring timeout on the same edge.
                if (PREADY) begin
                    state_d     = ST_RESP;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = PSLVERR;
                    rsp_rdata_d = pwrite_q ? '0 : PRDATA;
                end else if (tmo_expired) begin
                    state_d     = ST_RESP;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                psel_d      = 1'b0;
                penable_d   = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase

        cmd_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

`default_nettype wire

// File: tb/tb_apb_master.sv
// ============================================================================
// Module  : tb_apb_master
// Brief   : Directed self-checking bench for apb_master (TIMEOUT=4).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_master;

    localparam int DW = 32;
    localparam int AW = 16;

    logic          PCLK;
    logic          PRESETn;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic [DW-1:0] PRDATA;
    logic          PREADY;
    logic          PSLVERR;

    int nvec  = 0;
    int nfail = 0;

    apb_master #(
        .DW      (DW),
        .AW      (AW),
        .TIMEOUT (4)
    ) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge PCLK);
    endtask

    task automatic drive_cmd(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
    endtask

    task automatic check_setup(input string tag, input logic wr, input logic [AW-1:0] a);
        check({tag, "_psel"},    PSEL, 1);
        check({tag, "_penable"}, PENABLE, 0);
        check({tag, "_pwrite"},  PWRITE, wr);
        check({tag, "_paddr"},   PADDR, a);
        check({tag, "_cmdrdy"},  cmd_ready, 0);
    endtask

    task automatic check_access(input string tag, input logic [AW-1:0] a);
        check({tag, "_psel"},    PSEL, 1);
        check({tag, "_penable"}, PENABLE, 1);
        check({tag, "_paddr"},   PADDR, a);
        check({tag, "_rspv"},    rsp_valid, 0);
    endtask

    task automatic check_resp(input string tag, input logic [DW-1:0] rd, input logic err);
        check({tag, "_rspv"},  rsp_valid, 1);
        check({tag, "_rdata"}, rsp_rdata, rd);
        check({tag, "_err"},   rsp_err, err);
        check({tag, "_psel"},  PSEL, 0);
        check({tag, "_pen"},   PENABLE, 0);
        check({tag, "_crdy"},  cmd_ready, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired before end of sequence");
        $fatal(1, "watchdog");
    end

    initial begin
        PRESETn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b1;
        PRDATA    = '0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;

        // Reset state
        step(); step();
        check("rst_psel",    PSEL, 0);
        check("rst_penable", PENABLE, 0);
        check("rst_paddr",   PADDR, 0);
        check("rst_pwdata",  PWDATA, 0);
        check("rst_rspv",    rsp_valid, 0);
        check("rst_rdata",   rsp_rdata, 0);
        check("rst_err",     rsp_err, 0);
        PRESETn = 1'b1;
        step();
        check("rst_cmdrdy",  cmd_ready, 1);

        // Write, zero wait states
        drive_cmd(1'b1, 16'h0004, 32'hDEADBEEF);
        PREADY = 1'b1;
        step();
        cmd_valid = 1'b0;
        cmd_wdata = 32'h0;
        check_setup("wr_setup", 1'b1, 16'h0004);
        check("wr_setup_pwdata", PWDATA, 32'hDEADBEEF);
        step();
        check_access("wr_access", 16'h0004);
        check("wr_access_pwdata", PWDATA, 32'hDEADBEEF);
        step();
        check_resp("wr_resp", 32'h0, 1'b0);
        step();
        check("wr_done_rspv", rsp_valid, 0);
        check("wr_done_crdy", cmd_ready, 1);

        // Read with 3 wait states; PREADY lands on the would-be timeout edge
        drive_cmd(1'b0, 16'h0004, 32'h0);
        PREADY = 1'b0;
        PRDATA = 32'h12345678;
        step();
        cmd_valid = 1'b0;
        check_setup("rd_setup", 1'b0, 16'h0004);
        for (int i = 0; i < 4; i++) begin
            step();
            check_access("rd_access", 16'h0004);
        end
        PREADY = 1'b1;
        PRDATA = 32'hDEADBEEF;
        step();
        PREADY = 1'b0;
        PRDATA = 32'h0;
        check_resp("rd_resp", 32'hDEADBEEF, 1'b0);
        step();
        check("rd_done_crdy", cmd_ready, 1);

        // Slave error on a read
        drive_cmd(1'b0, 16'h000C, 32'h0);
        PREADY  = 1'b1;
        PSLVERR = 1'b1;
        PRDATA  = 32'hA5A5A5A5;
        step();
        cmd_valid = 1'b0;
        check_setup("se_setup", 1'b0, 16'h000C);
        step();
        check_access("se_access", 16'h000C);
        step();
        PSLVERR = 1'b0;
        PRDATA  = 32'h0;
        check_resp("se_resp", 32'hA5A5A5A5, 1'b1);
        step();

        // Timeout with PREADY held low
        drive_cmd(1'b0, 16'h0008, 32'h0);
        PREADY = 1'b0;
        PRDATA = 32'hFFFFFFFF;
        step();
        cmd_valid = 1'b0;
        check_setup("to_setup", 1'b0, 16'h0008);
        for (int i = 0; i < 4; i++) begin
            step();
            check_access("to_access", 16'h0008);
        end
        step();
        check_resp("to_resp", 32'h0, 1'b1);
        PRDATA = 32'h0;
        step();
        check("to_done_crdy", cmd_ready, 1);

        // Backpressure on the response; a pending command waits for the handshake
        rsp_ready = 1'b0;
        drive_cmd(1'b1, 16'h0010, 32'h11223344);
        PREADY = 1'b1;
        step();
        check_setup("bp_setup", 1'b1, 16'h0010);
        drive_cmd(1'b0, 16'h0020, 32'h0);
        step();
        check_access("bp_access", 16'h0010);
        check("bp_access_pwdata", PWDATA, 32'h11223344);
        for (int i = 0; i < 5; i++) begin
            step();
            check_resp("bp_hold", 32'h0, 1'b0);
        end
        rsp_ready = 1'b1;
        step();
        check("bp_hs_rspv",  rsp_valid, 0);
        check("bp_hs_crdy",  cmd_ready, 1);
        check("bp_hs_psel",  PSEL, 0);
        PRDATA = 32'hCAFEF00D;
        step();
        cmd_valid = 1'b0;
        check_setup("bp2_setup", 1'b0, 16'h0020);
        step();
        check_access("bp2_access", 16'h0020);
        step();
        check_resp("bp2_resp", 32'hCAFEF00D, 1'b0);
        PRDATA = 32'h0;
        step();

        // Reset pulsed during ACCESS
        drive_cmd(1'b0, 16'h0030, 32'h0);
        PREADY = 1'b0;
        step();
        cmd_valid = 1'b0;
        check_setup("ra_setup", 1'b0, 16'h0030);
        step();
        check_access("ra_access", 16'h0030);
        #2;
        PRESETn = 1'b0;
        #1;
        check("ra_async_psel",    PSEL, 0);
        check("ra_async_penable", PENABLE, 0);
        check("ra_async_paddr",   PADDR, 0);
        step();
        PRESETn = 1'b1;
        PREADY  = 1'b1;
        step();
        check("ra_rel_rspv", rsp_valid, 0);
        check("ra_rel_crdy", cmd_ready, 1);
        check("ra_rel_psel", PSEL, 0);
        drive_cmd(1'b1, 16'h0040, 32'h5555AAAA);
        step();
        cmd_valid = 1'b0;
        check_setup("ra2_setup", 1'b1, 16'h0040);
        check("ra2_pwdata", PWDATA, 32'h5555AAAA);
        step();
        check_access("ra2_access", 16'h0040);
        step();
        check_resp("ra2_resp", 32'h0, 1'b0);
        step();
        check("ra2_done_crdy", cmd_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

`default_nettype wire
